// File: rtl/obj_rom_arbiter.sv
// Two-client arbiter for the shared sprite-ROM SDRAM channel.
// Client A has priority; a starvation counter guarantees B a slot after STARVE_LIMIT A grants.
module obj_rom_arbiter #(
    parameter int unsigned AW           = 25,
    parameter int unsigned DW           = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_rdy,
    output logic [DW-1:0] a_data,
    input  logic          a_refresh_ok,

    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_rdy,
    output logic [DW-1:0] b_data,
    input  logic          b_refresh_ok,

    output logic          sdr_req,
    output logic [AW-1:0] sdr_addr,
    input  logic          sdr_rdy,
    input  logic [DW-1:0] sdr_data,
    output logic          sdr_refresh,

    output logic          err_overlap
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic          gnt_b_q, gnt_b_d;
    logic          pend_a_q, pend_a_d;
    logic          pend_b_q, pend_b_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] sdr_addr_q, sdr_addr_d;
    logic          refresh_q, refresh_d;
    logic          a_rdy_q, a_rdy_d;
    logic          b_rdy_q, b_rdy_d;
    logic [DW-1:0] a_data_q, a_data_d;
    logic [DW-1:0] b_data_q, b_data_d;
    logic          err_q, err_d;

    logic in_idle;
    logic busy_a, busy_b;
    logic a_acc, b_acc;
    logic a_eff, b_eff;
    logic pick_a, pick_b;
    logic done;

    // A client is busy while its request is latched or its transaction is on the channel.
    assign in_idle = (state_q == StIdle);
    assign busy_a  = pend_a_q | (~in_idle & ~gnt_b_q);
    assign busy_b  = pend_b_q | (~in_idle &  gnt_b_q);
    assign a_acc   = a_req & ~busy_a;
    assign b_acc   = b_req & ~busy_b;
    assign a_eff   = pend_a_q | a_acc;
    assign b_eff   = pend_b_q | b_acc;
    assign pick_a  = in_idle & a_eff & ~(b_eff & (starve_q >= StarveLimit));
    assign pick_b  = in_idle & b_eff & ~pick_a;
    assign done    = (state_q == StWait) & sdr_rdy;

    always_comb begin
        state_d    = state_q;
        gnt_b_d    = gnt_b_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        sdr_addr_d = sdr_addr_q;
        a_rdy_d    = a_rdy_q;
        b_rdy_d    = b_rdy_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;

        if (a_acc) begin
            pend_a_d = 1'b1;
            addr_a_d = a_addr;
            a_rdy_d  = 1'b0;
        end
        if (b_acc) begin
            pend_b_d = 1'b1;
            addr_b_d = b_addr;
            b_rdy_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (pick_a) begin
                    state_d    = StIssue;
                    gnt_b_d    = 1'b0;
                    sdr_addr_d = a_acc ? a_addr : addr_a_q;
                end else if (pick_b) begin
                    state_d    = StIssue;
                    gnt_b_d    = 1'b1;
                    sdr_addr_d = b_acc ? b_addr : addr_b_q;
                end
            end
            StIssue: begin
                state_d = StWait;
                if (gnt_b_q) begin
                    pend_b_d = 1'b0;
                end else begin
                    pend_a_d = 1'b0;
                end
            end
            StWait: begin
                if (sdr_rdy) begin
                    state_d = StIdle;
                    if (gnt_b_q) begin
                        b_rdy_d  = 1'b1;
                        b_data_d = sdr_data;
                    end else begin
                        a_rdy_d  = 1'b1;
                        a_data_d = sdr_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pick_b) begin
            starve_d = 4'd0;
        end else if (pick_a && b_eff) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
        end else if (!b_eff) begin
            starve_d = 4'd0;
        end
    end

    // Refresh only when the channel is quiet and both clients allow it.
    assign refresh_d = in_idle & ~pend_a_q & ~pend_b_q & ~a_req & ~b_req
                     & a_refresh_ok & b_refresh_ok;

    assign err_d = err_q | (a_req & busy_a) | (b_req & busy_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            gnt_b_q    <= 1'b0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            starve_q   <= 4'd0;
            sdr_addr_q <= '0;
            refresh_q  <= 1'b0;
            a_rdy_q    <= 1'b0;
            b_rdy_q    <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_b_q    <= gnt_b_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            starve_q   <= starve_d;
            sdr_addr_q <= sdr_addr_d;
            refresh_q  <= refresh_d;
            a_rdy_q    <= a_rdy_d;
            b_rdy_q    <= b_rdy_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            err_q      <= err_d;
        end
    end

    assign sdr_req     = (state_q == StIssue);
    assign sdr_addr    = sdr_addr_q;
    assign sdr_refresh = refresh_q;
    assign a_rdy       = a_rdy_q;
    assign b_rdy       = b_rdy_q;
    assign a_data      = a_data_q;
    assign b_data      = b_data_q;
    assign err_overlap = err_q;

endmodule

// File: tb/tb_obj_rom_arbiter.sv
// Bench for obj_rom_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_obj_rom_arbiter;

    localparam int AW  = 25;
    localparam int DW  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic          a_refresh_ok = 1'b1, b_refresh_ok = 1'b1;
    logic          a_rdy, b_rdy;
    logic [DW-1:0] a_data, b_data;
    logic          sdr_req;
    logic [AW-1:0] sdr_addr;
    logic          sdr_rdy = 1'b0;
    logic [DW-1:0] sdr_data = '0;
    logic          sdr_refresh;
    logic          err_overlap;

    always #5 clk = ~clk;

    obj_rom_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_rdy(a_rdy), .a_data(a_data),
        .a_refresh_ok(a_refresh_ok),
        .b_req(b_req), .b_addr(b_addr), .b_rdy(b_rdy), .b_data(b_data),
        .b_refresh_ok(b_refresh_ok),
        .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data),
        .sdr_refresh(sdr_refresh), .err_overlap(err_overlap)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs applied during the previous cycle, consumed by the model at the clock edge.
    bit            p_rst = 1;
    bit [1:0]      p_req = '0;
    logic [AW-1:0] p_addr [2];
    bit [1:0]      p_ok = 2'b11;
    bit            p_srdy = 0;
    logic [DW-1:0] p_sdata = '0;

    // Transaction-level model: per-client pending request, single outstanding transaction.
    bit [1:0]      m_pend;
    logic [AW-1:0] m_paddr [2];
    int            m_inf;
    bit            m_issue;
    int            m_starve;
    bit [1:0]      m_rdy;
    logic [DW-1:0] m_data [2];
    bit            m_err, m_ref;
    logic [AW-1:0] m_saddr;

    task automatic model_update();
        bit idle, done;
        bit [1:0] acc;
        int g;
        if (p_rst) begin
            m_pend = '0; m_inf = -1; m_issue = 0; m_starve = 0; m_rdy = '0;
            m_data[0] = '0; m_data[1] = '0; m_paddr[0] = '0; m_paddr[1] = '0;
            m_err = 0; m_ref = 0; m_saddr = '0;
            return;
        end
        idle  = (m_inf < 0);
        done  = !idle && !m_issue && p_srdy;
        m_ref = idle && (m_pend == 2'b00) && (p_req == 2'b00) && (p_ok == 2'b11);
        for (int c = 0; c < 2; c++) begin
            acc[c] = p_req[c] && !m_pend[c] && (m_inf != c);
            if (p_req[c] && !acc[c]) m_err = 1;
        end
        if (done) begin
            m_rdy[m_inf]  = 1;
            m_data[m_inf] = p_sdata;
            m_inf = -1;
        end
        for (int c = 0; c < 2; c++) begin
            if (acc[c]) begin
                m_pend[c]  = 1;
                m_paddr[c] = p_addr[c];
                m_rdy[c]   = 0;
            end
        end
        g = -1;
        if (idle) begin
            if (m_pend[0] && !(m_pend[1] && m_starve >= LIM)) g = 0;
            else if (m_pend[1]) g = 1;
        end
        if (g == 1) m_starve = 0;
        else if (g == 0 && m_pend[1]) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else if (!m_pend[1]) m_starve = 0;
        m_issue = (g >= 0);
        if (g >= 0) begin
            m_saddr   = m_paddr[g];
            m_pend[g] = 0;
            m_inf     = g;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("sdr_req", 64'(sdr_req), 64'(m_issue));
            check("sdr_addr", 64'(sdr_addr), 64'(m_saddr));
            check("sdr_refresh", 64'(sdr_refresh), 64'(m_ref));
            check("a_rdy", 64'(a_rdy), 64'(m_rdy[0]));
            check("b_rdy", 64'(b_rdy), 64'(m_rdy[1]));
            check("a_data", a_data, m_data[0]);
            check("b_data", b_data, m_data[1]);
            check("err_overlap", 64'(err_overlap), 64'(m_err));
            check("starve_cnt", 64'(dut.starve_q), 64'(m_starve));
        end
    end

    // SDRAM responder and monitor state.
    int            rsp_cnt = 0;
    int            rsp_delay = 0;     // 0 selects a random delay
    bit            rsp_rand = 1;
    logic [DW-1:0] rsp_fix = '0;
    bit            spur_en = 0;
    int            auto_a_left = 0;
    logic [AW-1:0] auto_addr = '0;
    int            iss_cyc [$];
    logic [AW-1:0] iss_addr [$];
    int            iss_st [$];
    int            rdy_cyc [$];
    logic [DW-1:0] rdy_data [$];

    task automatic clear_q();
        iss_cyc.delete(); iss_addr.delete(); iss_st.delete();
        rdy_cyc.delete(); rdy_data.delete();
    endtask

    task automatic step(input bit ar, input logic [AW-1:0] aa, input bit br,
                        input logic [AW-1:0] ba, input bit aok, input bit bok, input bit rst);
        bit srdy;
        logic [DW-1:0] sd;
        @(posedge clk);
        model_update();
        if (p_rst) rsp_cnt = 0;
        cyc++;
        #1;
        srdy = 0;
        sd   = {$urandom, $urandom};
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                srdy = 1;
                if (!rsp_rand) sd = rsp_fix;
                rdy_cyc.push_back(cyc);
                rdy_data.push_back(sd);
            end
        end
        if (sdr_req === 1'b1) begin
            iss_cyc.push_back(cyc);
            iss_addr.push_back(sdr_addr);
            iss_st.push_back(int'(dut.starve_q));
            rsp_cnt = (rsp_delay > 0) ? rsp_delay : $urandom_range(1, 5);
        end else if (spur_en && !srdy && rsp_cnt == 0 && m_inf < 0
                     && $urandom_range(0, 7) == 0) begin
            srdy = 1;
        end
        if (auto_a_left > 0 && a_rdy === 1'b1) begin
            ar = 1;
            aa = auto_addr;
            auto_addr++;
            auto_a_left--;
        end
        reset = rst; a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
        a_refresh_ok = aok; b_refresh_ok = bok; sdr_rdy = srdy; sdr_data = sd;
        p_rst = rst; p_req = {br, ar}; p_addr[0] = aa; p_addr[1] = ba;
        p_ok = {bok, aok}; p_srdy = srdy; p_sdata = sd;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, 0, '0, 1, 1, 0);
    endtask

    task automatic do_reset();
        step(0, '0, 0, '0, 1, 1, 1);
        idle(1);
    endtask

    task automatic single_a();
        rsp_delay = 4; rsp_rand = 0; rsp_fix = 64'hDEADBEEF_CAFEF00D;
        clear_q();
        step(1, 25'h0123400, 0, '0, 1, 1, 0);
        idle(1);
        check("single_sdr_req_t1", 64'(sdr_req), 64'd1);
        check("single_sdr_addr_t1", 64'(sdr_addr), 64'h0123400);
        for (int k = 2; k <= 5; k++) begin
            idle(1);
            check("single_sdr_req_quiet", 64'(sdr_req), 64'd0);
            check("single_a_rdy_early", 64'(a_rdy), 64'd0);
        end
        idle(1);
        check("single_a_rdy_t6", 64'(a_rdy), 64'd1);
        check("single_a_data_t6", a_data, 64'hDEADBEEF_CAFEF00D);
        check("single_b_rdy", 64'(b_rdy), 64'd0);
        check("single_issue_count", 64'(iss_cyc.size()), 64'd1);
        idle(2);
    endtask

    initial begin
        int guard;
        p_addr[0] = '0; p_addr[1] = '0;
        step(0, '0, 0, '0, 1, 1, 1);
        chk_en = 1;
        idle(1);
        check("reset_sdr_req", 64'(sdr_req), 64'd0);
        check("reset_sdr_addr", 64'(sdr_addr), 64'd0);
        check("reset_refresh", 64'(sdr_refresh), 64'd0);
        check("reset_rdy", 64'({a_rdy, b_rdy}), 64'd0);
        check("reset_err", 64'(err_overlap), 64'd0);

        single_a();

        // Simultaneous requests: A first, B two cycles after A's completion.
        rsp_delay = 2; rsp_rand = 1; clear_q();
        step(1, 25'h100, 1, 25'h200, 1, 1, 0);
        guard = 0;
        while (rdy_cyc.size() < 2 && guard < 40) begin idle(1); guard++; end
        idle(1);
        if (rdy_cyc.size() < 2 || iss_cyc.size() < 2) begin
            n_tests++; n_fail++;
            $display("FAIL simul_timeout: issues %0d, completions %0d, required 2 each",
                     iss_cyc.size(), rdy_cyc.size());
        end else begin
            check("simul_first_addr", 64'(iss_addr[0]), 64'h100);
            check("simul_second_addr", 64'(iss_addr[1]), 64'h200);
            check("simul_gap", 64'(iss_cyc[1] - rdy_cyc[0]), 64'd2);
            check("simul_a_data", a_data, rdy_data[0]);
            check("simul_b_data", b_data, rdy_data[1]);
        end

        // Starvation guard: A re-requests on every a_rdy while B waits.
        do_reset();
        rsp_delay = 1; clear_q();
        auto_a_left = 4; auto_addr = 25'hA01;
        step(1, 25'hA00, 1, 25'hB00, 1, 1, 0);
        guard = 0;
        while (iss_cyc.size() < 6 && guard < 80) begin idle(1); guard++; end
        auto_a_left = 0;
        idle(4);
        if (iss_cyc.size() < 6) begin
            n_tests++; n_fail++;
            $display("FAIL starve_timeout: issues %0d, required 6", iss_cyc.size());
        end else begin
            logic [AW-1:0] ea [6];
            int es [6];
            ea = '{25'hA00, 25'hA01, 25'hA02, 25'hA03, 25'hB00, 25'hA04};
            es = '{1, 2, 3, 4, 0, 0};
            for (int i = 0; i < 6; i++) begin
                check($sformatf("starve_order_%0d", i), 64'(iss_addr[i]), 64'(ea[i]));
                check($sformatf("starve_cnt_%0d", i), 64'(iss_st[i]), 64'(es[i]));
            end
        end

        // Refresh gating.
        do_reset();
        idle(2);
        check("refresh_idle_ok", 64'(sdr_refresh), 64'd1);
        step(0, '0, 0, '0, 1, 0, 0);
        idle(1);
        check("refresh_b_ok_fell", 64'(sdr_refresh), 64'd0);
        idle(2);
        check("refresh_restored", 64'(sdr_refresh), 64'd1);
        rsp_delay = 3;
        step(0, '0, 1, 25'h321, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("refresh_busy", 64'(sdr_refresh), 64'd0);
        end
        idle(4);

        // Overlap: second a_req while A is in WAIT.
        do_reset();
        rsp_delay = 6; clear_q();
        step(1, 25'h55, 0, '0, 1, 1, 0);
        idle(2);
        step(1, 25'h66, 0, '0, 1, 1, 0);
        idle(1);
        check("overlap_err", 64'(err_overlap), 64'd1);
        idle(6);
        check("overlap_issue_count", 64'(iss_cyc.size()), 64'd1);
        check("overlap_done", 64'(a_rdy), 64'd1);
        check("overlap_err_sticky", 64'(err_overlap), 64'd1);

        // Reset during WAIT.
        step(1, 25'h77, 0, '0, 1, 1, 0);
        idle(3);
        do_reset();
        check("midrst_outputs", 64'({sdr_req, sdr_refresh, a_rdy, b_rdy, err_overlap}), 64'd0);
        check("midrst_addr", 64'(sdr_addr), 64'd0);
        check("midrst_data", a_data | b_data, 64'd0);
        single_a();

        // Randomized traffic.
        rsp_delay = 0; rsp_rand = 1; spur_en = 1;
        begin
            bit aok = 1, bok = 1;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 15) == 0) aok = ~aok;
                if ($urandom_range(0, 15) == 0) bok = ~bok;
                step($urandom_range(0, 3) == 0, AW'($urandom), $urandom_range(0, 3) == 0,
                     AW'($urandom), aok, bok, $urandom_range(0, 399) == 0);
            end
        end
        spur_en = 0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
